// File: rtl/decimal_key_pkg.sv
// Shared types and helpers for the decimal key encoder: FSM states and
// the highest-digit priority encoder used on the synchronized key lines.
package decimal_key_pkg;

  localparam int NUM_KEYS = 10;
  localparam int BCD_W    = 4;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESENT,
    RELEASE
  } state_t;

  // Later (higher) digits overwrite earlier ones, so the highest pressed digit wins.
  function automatic logic [BCD_W-1:0] prio_enc10(input logic [NUM_KEYS-1:0] pressed);
    logic [BCD_W-1:0] code;
    code = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (pressed[k]) code = BCD_W'(k);
    end
    return code;
  endfunction

  function automatic logic multi_press(input logic [NUM_KEYS-1:0] pressed);
    int n;
    n = 0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (pressed[k]) n++;
    end
    return (n > 1);
  endfunction

endpackage

// File: rtl/decimal_key_sync.sv
// Multi-flop synchronizer for the asynchronous active-low key lines.
// Resets to all ones so every key reads as released after reset.
module decimal_key_sync
  import decimal_key_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NUM_KEYS-1:0] i_n_key,
  output logic [NUM_KEYS-1:0] o_key_s
);

  logic [NUM_KEYS-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '1;
      end
    end else begin
      sync_q[0] <= i_n_key;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign o_key_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/decimal_key_encoder.sv
// Debounced 10-key to BCD encoder: one code per press, highest digit wins,
// offered downstream over a valid/ready handshake.
module decimal_key_encoder
  import decimal_key_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NUM_KEYS-1:0] i_n_key,
  input  logic                i_en,
  input  logic                i_ready,
  output logic                o_a,
  output logic                o_b,
  output logic                o_c,
  output logic                o_d,
  output logic                o_multi,
  output logic                o_valid,
  output logic                o_busy
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] key_s;
  logic [NUM_KEYS-1:0] pressed;
  logic                any_pressed;
  logic [BCD_W-1:0]    code;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [BCD_W-1:0]    cand, cand_nxt;
  logic [BCD_W-1:0]    bcd;
  logic                capture;
  logic                valid_nxt;

  decimal_key_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_n_key (i_n_key),
    .o_key_s (key_s)
  );

  assign pressed     = ~key_s;
  assign any_pressed = |pressed;
  assign code        = prio_enc10(pressed);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cand_nxt  = cand;
    capture   = 1'b0;
    valid_nxt = o_valid;
    case (state)
      IDLE: begin
        if (any_pressed && i_en) begin
          cand_nxt  = code;
          cnt_nxt   = '0;
          state_nxt = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        // Any change of the winning digit restarts the press from IDLE.
        if (!i_en || !any_pressed || (code != cand)) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          capture   = 1'b1;
          valid_nxt = 1'b1;
          state_nxt = PRESENT;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      PRESENT: begin
        if (o_valid && i_ready) begin
          valid_nxt = 1'b0;
          cnt_nxt   = '0;
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        // Any key still down holds off re-arming, which prevents auto-repeat.
        if (any_pressed) begin
          cnt_nxt = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      cand    <= '0;
      bcd     <= '0;
      o_multi <= 1'b0;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      cand    <= cand_nxt;
      o_valid <= valid_nxt;
      o_busy  <= (state_nxt != IDLE);
      if (capture) begin
        bcd     <= cand;
        o_multi <= multi_press(pressed);
      end
    end
  end

  assign {o_a, o_b, o_c, o_d} = bcd;

endmodule

// File: tb/tb_decimal_key_encoder.sv
// Bench for decimal_key_encoder: table-driven presses, hand-written corner
// sequences and randomized press/release episodes against a timing model.
module tb_decimal_key_encoder;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int LAT  = SYNC + DEB + 1;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic [9:0] i_n_key;
  logic       i_en;
  logic       i_ready;
  logic       o_a, o_b, o_c, o_d, o_multi, o_valid, o_busy;
  logic [3:0] code_o;

  assign code_o = {o_a, o_b, o_c, o_d};

  always #5 i_clk = ~i_clk;

  decimal_key_encoder #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_n_key (i_n_key),
    .i_en    (i_en),
    .i_ready (i_ready),
    .o_a     (o_a),
    .o_b     (o_b),
    .o_c     (o_c),
    .o_d     (o_d),
    .o_multi (o_multi),
    .o_valid (o_valid),
    .o_busy  (o_busy)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int edge_n = 0;

  typedef struct {
    logic [9:0] n_key;
    int         hold;
    logic       en;
    int         exp_n;
    int         exp_code;
    int         exp_multi;
  } vec_t;

  typedef struct {
    int e;
    int code;
    int multi;
  } evt_t;

  vec_t tbl[8];
  evt_t exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
  endtask

  task automatic tick();
    @(posedge i_clk);
    edge_n++;
    #1;
  endtask

  task automatic idle_cycles(input int n);
    i_n_key = '1;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drive one press for 'hold' cycles, then release and let the FSM settle.
  task automatic run_press(input logic [9:0] nk, input int hold, input logic en,
                           output int nv, output int off, output int code, output int multi);
    int e0;
    e0 = edge_n; nv = 0; off = -1; code = -1; multi = -1;
    i_n_key = nk;
    i_en    = en;
    for (int i = 0; i < hold + DEB + SYNC + 6; i++) begin
      if (i == hold) begin
        i_n_key = '1;
        i_en    = 1'b1;
      end
      tick();
      if (o_valid) begin
        if (nv == 0) begin
          off   = edge_n - e0;
          code  = int'(code_o);
          multi = int'(o_multi);
        end
        nv++;
      end
    end
  endtask

  function automatic int hi_digit(input logic [9:0] mask);
    for (int k = 9; k >= 0; k--) if (mask[k]) return k;
    return -1;
  endfunction

  initial begin
    int nv, off, code, multi, cnt, first_e, e0, r;
    logic [9:0] mask;
    int h, g;
    bit exp_v;

    tbl[0] = '{10'h37F, 20, 1'b1, 1, 7, 0};
    tbl[1] = '{10'h1FB, 10, 1'b1, 1, 9, 1};
    tbl[2] = '{10'h3FE,  8, 1'b1, 1, 0, 0};
    tbl[3] = '{10'h1FF,  5, 1'b1, 1, 9, 0};
    tbl[4] = '{10'h3F7,  4, 1'b1, 0, 0, 0};
    tbl[5] = '{10'h000,  8, 1'b1, 1, 9, 1};
    tbl[6] = '{10'h3DF, 10, 1'b0, 0, 0, 0};
    tbl[7] = '{10'h3E9, 10, 1'b1, 1, 4, 1};

    // Reset
    i_rst_n = 1'b0; i_n_key = '1; i_en = 1'b1; i_ready = 1'b1;
    tick(); tick();
    chk("reset_valid", int'(o_valid), 0);
    chk("reset_busy",  int'(o_busy),  0);
    chk("reset_code",  int'(code_o),  0);
    chk("reset_multi", int'(o_multi), 0);
    i_rst_n = 1'b1;
    idle_cycles(3);

    // Table-driven single presses
    foreach (tbl[i]) begin
      run_press(tbl[i].n_key, tbl[i].hold, tbl[i].en, nv, off, code, multi);
      chk($sformatf("tbl%0d_nvalid", i), nv, tbl[i].exp_n);
      if (tbl[i].exp_n > 0) begin
        chk($sformatf("tbl%0d_latency", i), off,   LAT);
        chk($sformatf("tbl%0d_code", i),    code,  tbl[i].exp_code);
        chk($sformatf("tbl%0d_multi", i),   multi, tbl[i].exp_multi);
      end
    end

    // Bouncing key 3, then held
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      i_n_key = (i % 2 == 0) ? 10'h3F7 : 10'h3FF;
      tick();
      if (o_valid) cnt++;
    end
    i_n_key = 10'h3F7;
    e0 = edge_n; first_e = -1; code = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (o_valid) begin
        if (first_e < 0) begin
          first_e = edge_n - e0;
          code = int'(code_o);
        end
        cnt++;
      end
    end
    chk("bounce_nvalid",  cnt,     1);
    chk("bounce_latency", first_e, LAT);
    chk("bounce_code",    code,    3);
    idle_cycles(DEB + SYNC + 4);

    // Backpressure: held code ignores key changes until accepted
    i_ready = 1'b0;
    i_n_key = 10'h3DF;
    for (int i = 0; i < LAT - 1; i++) tick();
    chk("bp_valid_early", int'(o_valid), 0);
    tick();
    chk("bp_valid", int'(o_valid), 1);
    chk("bp_code",  int'(code_o),  5);
    chk("bp_busy",  int'(o_busy),  1);
    i_n_key = 10'h3FF;
    for (int i = 0; i < 3; i++) tick();
    i_n_key = 10'h3BF;
    for (int i = 0; i < 10; i++) tick();
    chk("bp_valid_hold", int'(o_valid), 1);
    chk("bp_code_hold",  int'(code_o),  5);
    i_ready = 1'b1;
    tick();
    chk("bp_transfer", int'(o_valid), 0);
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (o_valid) cnt++;
    end
    chk("bp_no_repeat", cnt, 0);
    chk("bp_code_kept", int'(code_o), 5);
    idle_cycles(DEB + SYNC + 4);
    run_press(10'h3BF, 10, 1'b1, nv, off, code, multi);
    chk("bp_repress_nvalid", nv,   1);
    chk("bp_repress_code",   code, 6);

    // Reset while presenting, key kept held
    i_ready = 1'b0;
    i_n_key = 10'h3EF;
    for (int i = 0; i < LAT; i++) tick();
    chk("rst_pre_valid", int'(o_valid), 1);
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_busy",  int'(o_busy),  0);
    chk("rst_code",  int'(code_o),  0);
    cnt = 0;
    for (int i = 1; i < LAT; i++) begin
      tick();
      if (o_valid) cnt++;
    end
    chk("rst_no_early", cnt, 0);
    tick();
    chk("rst_rereport_valid", int'(o_valid), 1);
    chk("rst_rereport_code",  int'(code_o),  4);
    i_ready = 1'b1;
    tick();
    idle_cycles(DEB + SYNC + 6);

    // Randomized clean press/release episodes
    exp_q.delete();
    for (int ep = 0; ep < 40; ep++) begin
      mask = 10'($urandom_range(1, 1023));
      h = $urandom_range(1, 10);
      g = $urandom_range(DEB + 2, DEB + 6);
      e0 = edge_n;
      if (h >= DEB + 1)
        exp_q.push_back('{e0 + LAT, hi_digit(mask), ($countones(mask) > 1) ? 1 : 0});
      for (int i = 0; i < h + g; i++) begin
        i_n_key = (i < h) ? ~mask : 10'h3FF;
        tick();
        exp_v = (exp_q.size() > 0) && (exp_q[0].e == edge_n);
        chk($sformatf("rnd%0d_valid", ep), int'(o_valid), int'(exp_v));
        if (exp_v) begin
          chk($sformatf("rnd%0d_code", ep),  int'(code_o),  exp_q[0].code);
          chk($sformatf("rnd%0d_multi", ep), int'(o_multi), exp_q[0].multi);
          r = exp_q[0].e;
          exp_q.pop_front();
        end
      end
    end
    chk("rnd_all_reported", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
